// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-clock divider, raster counters,
// latency-matched sync/blank outputs and a once-per-frame shadow of game state.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CLK_DIV  = 2,
    parameter int PIPE_LAT = 2,
    parameter int CW       = 10,
    parameter int SHADOW_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [SHADOW_W-1:0] shadow_in,
    output logic                pix_en,
    output logic                vga_clk,
    output logic [CW-1:0]       hcount,
    output logic [CW-1:0]       vcount,
    output logic                bright,
    output logic                hsync,
    output logic                vsync,
    output logic                vga_blank_n,
    output logic                line_start,
    output logic                frame_start,
    output logic [SHADOW_W-1:0] shadow_out
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = $clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SS     = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SE     = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_SS     = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SE     = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          HS_ON    = 1'(HS_POL);
    localparam logic          VS_ON    = 1'(VS_POL);

    logic [DW-1:0]       div_cnt_r;
    logic                vga_clk_r;
    logic [CW-1:0]       hcount_r;
    logic [CW-1:0]       vcount_r;
    logic [SHADOW_W-1:0] shadow_r;
    logic                pix_en_s;
    logic                line_s;
    logic                frame_s;
    logic                bright_s;
    logic                hs_lvl_s;
    logic                vs_lvl_s;

    // Pixel-clock divider and DAC clock; both freeze while en is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_r <= {DW{1'b0}};
            vga_clk_r <= 1'b0;
        end else if (en) begin
            div_cnt_r <= (div_cnt_r == DIV_LAST) ? {DW{1'b0}} : div_cnt_r + DW'(1);
            vga_clk_r <= (div_cnt_r >= DIV_HALF);
        end
    end

    // Raster counters, advancing once per pixel tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount_r <= {CW{1'b0}};
            vcount_r <= {CW{1'b0}};
        end else if (pix_en_s) begin
            if (hcount_r == H_LAST) begin
                hcount_r <= {CW{1'b0}};
                vcount_r <= (vcount_r == V_LAST) ? {CW{1'b0}} : vcount_r + CW'(1);
            end else begin
                hcount_r <= hcount_r + CW'(1);
            end
        end
    end

    // Frame-stable copy of the game state, captured in the frame-wrap cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_r <= {SHADOW_W{1'b0}};
        end else if (frame_s) begin
            shadow_r <= shadow_in;
        end
    end

    // Strobes and raw raster flags; bright is held low while reset is asserted
    always_comb begin
        pix_en_s = en && (div_cnt_r == DIV_LAST);
        line_s   = pix_en_s && (hcount_r == H_LAST);
        frame_s  = line_s && (vcount_r == V_LAST);
        bright_s = rst && (hcount_r < H_ACT) && (vcount_r < V_ACT);
        hs_lvl_s = ((hcount_r >= H_SS) && (hcount_r < H_SE)) ? HS_ON : ~HS_ON;
        vs_lvl_s = ((vcount_r >= V_SS) && (vcount_r < V_SE)) ? VS_ON : ~VS_ON;
    end

    generate
        if (PIPE_LAT == 0) begin : g_nodelay
            // No downstream latency to match: sync/blank follow the raw flags
            always_comb begin
                hsync       = hs_lvl_s;
                vsync       = vs_lvl_s;
                vga_blank_n = bright_s;
            end
        end else begin : g_delay
            logic [PIPE_LAT-1:0] hs_pipe_r;
            logic [PIPE_LAT-1:0] vs_pipe_r;
            logic [PIPE_LAT-1:0] bl_pipe_r;

            // Latency-matching shift register, one stage per pixel tick
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    hs_pipe_r <= {PIPE_LAT{~HS_ON}};
                    vs_pipe_r <= {PIPE_LAT{~VS_ON}};
                    bl_pipe_r <= {PIPE_LAT{1'b0}};
                end else if (pix_en_s) begin
                    hs_pipe_r <= (hs_pipe_r << 1) | PIPE_LAT'(hs_lvl_s);
                    vs_pipe_r <= (vs_pipe_r << 1) | PIPE_LAT'(vs_lvl_s);
                    bl_pipe_r <= (bl_pipe_r << 1) | PIPE_LAT'(bright_s);
                end
            end

            // Oldest stage drives the pins
            always_comb begin
                hsync       = hs_pipe_r[PIPE_LAT-1];
                vsync       = vs_pipe_r[PIPE_LAT-1];
                vga_blank_n = bl_pipe_r[PIPE_LAT-1];
            end
        end
    endgenerate

    assign pix_en      = pix_en_s;
    assign vga_clk     = vga_clk_r;
    assign hcount      = hcount_r;
    assign vcount      = vcount_r;
    assign bright      = bright_s;
    assign line_start  = line_s;
    assign frame_start = frame_s;
    assign shadow_out  = shadow_r;
endmodule
